time_to_count: RTL

- Inverse of the stopwatch field decoder: converts a decimal time entry (minutes, seconds, centiseconds) into the raw binary centisecond count.
- The count has the same width and scale as the stopwatch main counter (1 LSB = 0.01 s).
- Feeds preset/load values into the counter, for example a countdown start value or a restored lap time.
- Multi-cycle shift-add evaluator with a start/busy/done handshake and range checking.

---
 rtl/time_to_count.sv | 112 +++++++++++
 1 files changed

// File: rtl/time_to_count.sv
// Decimal mm:ss.cc entry to binary centisecond count.
// Horner shift-add evaluator with start/busy/done handshake.
module time_to_count #(
  parameter int CW      = 24,
  parameter int MAX_MIN = 99
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [6:0]    min_in,
  input  logic [5:0]    sec_in,
  input  logic [6:0]    cs_in,
  output logic [CW-1:0] count,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE,
    MUL60,
    MUL100,
    FINISH
  } state_t;

  localparam logic [6:0] MAXM = 7'(MAX_MIN);

  state_t        state;
  state_t        state_nx;
  logic [6:0]    min_q;
  logic [5:0]    sec_q;
  logic [6:0]    cs_q;
  logic [CW-1:0] acc;
  logic [CW-1:0] m_ext;
  logic [CW-1:0] m60;
  logic [CW-1:0] a100;
  logic          in_range;

  assign in_range = (min_in <= MAXM)
                 && (sec_in <= 6'd59)
                 && (cs_in  <= 7'd99);

  // x*60 and x*100 as shift-add, no multiplier
  assign m_ext = CW'(min_q);
  assign m60   = (m_ext << 6) - (m_ext << 2);
  assign a100  = (acc << 6) + (acc << 5) + (acc << 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start && in_range) begin
          state_nx = MUL60;
        end
      end
      MUL60:  state_nx = MUL100;
      MUL100: state_nx = FINISH;
      FINISH: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= '0;
      sec_q <= '0;
      cs_q  <= '0;
      acc   <= '0;
      count <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (in_range) begin
              min_q <= min_in;
              sec_q <= sec_in;
              cs_q  <= cs_in;
            end else begin
              err <= 1'b1;
            end
          end
        end
        MUL60: begin
          acc <= m60 + CW'(sec_q);
        end
        MUL100: begin
          acc <= a100 + CW'(cs_q);
        end
        FINISH: begin
          count <= acc;
          done  <= 1'b1;
        end
      endcase
    end
  end

endmodule
